// File: rtl/data_mem_resp.sv
// Data-memory responder for the memory stage: accepts one load/store request,
// inserts WAIT_CYCLES wait states, then pulses done with rdata/err valid.
// Stores use per-lane byte enables; loads return right-aligned, zero-extended data.
module data_mem_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  access_size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int LO_W  = IDX_W + 2;
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;
    logic [3:0] wait_cnt;

    logic             we_p0;
    logic [1:0]       size_p0;
    logic [LO_W-1:0]  addr_p0;
    logic [31:0]      wdata_p0;
    logic             illegal_p0;

    logic             accept;
    logic             illegal_in;
    logic             fire;
    logic             op_from_in;
    logic             op_we;
    logic [1:0]       op_size;
    logic [LO_W-1:0]  op_addr;
    logic [31:0]      op_wdata;
    logic [IDX_W-1:0] op_idx;
    logic [3:0]       op_be;
    logic [31:0]      op_lanes;
    logic [31:0]      rd_word;

    logic [31:0] mem [DEPTH_WORDS];

    // Misaligned, unsupported size, or beyond the end of the array.
    function automatic logic is_illegal(input logic [1:0] size, input logic [31:0] a);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_WORD: bad = (a[1:0] != 2'b00);
            SZ_HALF: bad = a[0];
            SZ_BYTE: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        if ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS))
            bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_WORD: be = 4'b1111;
            SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            SZ_BYTE: be = 4'b0001 << lo;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate narrow store data so whichever lanes are enabled see it.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] lanes;
        case (size)
            SZ_HALF: lanes = {2{wd[15:0]}};
            SZ_BYTE: lanes = {4{wd[7:0]}};
            default: lanes = wd;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] load_align(input logic [1:0] size, input logic [1:0] lo,
                                               input logic [31:0] word);
        logic [31:0] shifted;
        logic [31:0] res;
        shifted = word >> {lo, 3'b000};
        case (size)
            SZ_HALF: res = {16'h0000, shifted[15:0]};
            SZ_BYTE: res = {24'h000000, shifted[7:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    assign accept     = rst_n && (state == IDLE) && req;
    assign illegal_in = is_illegal(access_size, addr);

    // The operation fires on the edge entering DONE; with no wait states that
    // edge is the accept edge, so the live inputs are used instead of the latch.
    assign op_from_in = (state == IDLE);
    assign op_we      = op_from_in ? we                : we_p0;
    assign op_size    = op_from_in ? access_size       : size_p0;
    assign op_addr    = op_from_in ? addr[LO_W-1:0]    : addr_p0;
    assign op_wdata   = op_from_in ? wdata             : wdata_p0;
    assign op_idx     = op_addr[LO_W-1:2];
    assign op_be      = byte_en(op_size, op_addr[1:0]);
    assign op_lanes   = store_lanes(op_size, op_wdata);
    assign rd_word    = mem[op_idx];

    assign busy = accept || (state == WAIT);
    assign done = (state == DONE);
    assign err  = (state == DONE) && illegal_p0;

    // Next-state logic; fire marks a legal access completing on this edge.
    always_comb begin
        state_next = state;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (illegal_in) begin
                        state_next = DONE;
                    end else if (WAIT_CYCLES > 0) begin
                        state_next = WAIT;
                    end else begin
                        state_next = DONE;
                        fire       = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = DONE;
                    fire       = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register and wait-state counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_next;
            if (accept && !illegal_in)
                wait_cnt <= WAIT_LOAD;
            else if ((state == WAIT) && (wait_cnt != 4'd0))
                wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Request capture stage (p0): held for the wait states.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0      <= we;
            size_p0    <= access_size;
            addr_p0    <= addr[LO_W-1:0];
            wdata_p0   <= wdata;
            illegal_p0 <= illegal_in;
        end
    end

    // Load result register; holds until the next legal load completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= 32'h0;
        else if (fire && !op_we)
            rdata <= load_align(op_size, op_addr[1:0], rd_word);
    end

    // Byte-enabled store into the data array.
    always_ff @(posedge clk) begin
        if (fire && op_we) begin
            for (int i = 0; i < 4; i++) begin
                if (op_be[i])
                    mem[op_idx][8*i +: 8] <= op_lanes[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: one instance with two wait states and one
// with none, sharing clock, reset and request fields.
module tb_data_mem_resp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  access_size = 2'b00;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata_a, rdata_b;
    logic        busy_a, busy_b, done_a, done_b, err_a, err_b;

    int tests_run = 0;
    int tests_failed = 0;

    data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .we(we), .access_size(access_size),
        .addr(addr), .wdata(wdata), .rdata(rdata_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .we(we), .access_size(access_size),
        .addr(addr), .wdata(wdata), .rdata(rdata_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Issue one request on instance a (sel=0) or b (sel=1) and wait for done.
    task automatic do_req(input bit sel, input bit w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic e,
                          output int cycles, output int busy_cnt, output bit err_early);
        bit seen;
        seen = 0;
        cycles = 0;
        busy_cnt = 0;
        err_early = 0;
        rd = 32'h0;
        e = 1'b0;
        @(posedge clk); #1;
        we = w; access_size = sz; addr = a; wdata = wd;
        if (sel) req_b = 1'b1; else req_a = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (sel ? busy_b : busy_a) busy_cnt++;
            if (sel ? err_b : err_a) err_early = 1;
            @(posedge clk); #1;
            cycles++;
            if (sel ? done_b : done_a) begin
                rd = sel ? rdata_b : rdata_a;
                e  = sel ? err_b : err_a;
                seen = 1;
                break;
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        if (!seen) begin
            tests_run++;
            tests_failed++;
            $display("FAIL done_timeout: addr=%h no done within 40 cycles", a);
        end
    endtask

    task automatic test_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        #3;
        tests_run++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: got a=%b b=%b want 0", busy_a, busy_b);
        end
        tests_run++;
        if (done_a !== 1'b0 || err_a !== 1'b0 || rdata_a !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: done=%b err=%b rdata=%h want 0/0/0", done_a, err_a, rdata_a);
        end
        @(negedge clk);
        req_a = 1'b0;
        req_b = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic e; int cyc, bc; bit ee;
        do_req(0, 1, 2'b00, 32'h10, 32'hDEADBEEF, rd, e, cyc, bc, ee);
        tests_run++;
        if (cyc !== 3 || bc !== 3 || e !== 1'b0 || ee) begin
            tests_failed++;
            $display("FAIL sw_timing: cycles=%0d busy=%0d err=%b early=%b want 3/3/0/0", cyc, bc, e, ee);
        end
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL sw_rdata_hold: got %h want 00000000", rd);
        end
        do_req(0, 0, 2'b00, 32'h10, 32'h0, rd, e, cyc, bc, ee);
        tests_run++;
        if (cyc !== 3 || bc !== 3 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL lw_basic: cycles=%0d busy=%0d err=%b rdata=%h want 3/3/0/deadbeef", cyc, bc, e, rd);
        end
    endtask

    task automatic test_subword();
        logic [31:0] rd; logic e; int cyc, bc; bit ee;
        do_req(0, 1, 2'b10, 32'h13, 32'h000000AA, rd, e, cyc, bc, ee);
        tests_run++;
        if (e !== 1'b0 || rd !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL sb_done: err=%b rdata=%h want 0/deadbeef", e, rd);
        end
        do_req(0, 0, 2'b00, 32'h10, 32'h0, rd, e, cyc, bc, ee);
        tests_run++;
        if (rd !== 32'hAAADBEEF) begin
            tests_failed++;
            $display("FAIL lw_after_sb: got %h want aaadbeef", rd);
        end
        do_req(0, 0, 2'b10, 32'h12, 32'h0, rd, e, cyc, bc, ee);
        tests_run++;
        if (rd !== 32'h000000AD || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL lb_lane2: got %h err=%b want 000000ad/0", rd, e);
        end
        do_req(0, 0, 2'b01, 32'h12, 32'h0, rd, e, cyc, bc, ee);
        tests_run++;
        if (rd !== 32'h0000AAAD || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL lh_upper: got %h err=%b want 0000aaad/0", rd, e);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] rd; logic e; int cyc, bc; bit ee;
        do_req(0, 1, 2'b00, 32'h20, 32'h55667788, rd, e, cyc, bc, ee);
        do_req(0, 0, 2'b01, 32'h11, 32'h0, rd, e, cyc, bc, ee);
        tests_run++;
        if (cyc !== 1 || e !== 1'b1 || rd !== 32'h0000AAAD || ee) begin
            tests_failed++;
            $display("FAIL lh_misaligned: cycles=%0d err=%b rdata=%h early=%b want 1/1/0000aaad/0", cyc, e, rd, ee);
        end
        do_req(0, 1, 2'b00, 32'h22, 32'hFFFFFFFF, rd, e, cyc, bc, ee);
        tests_run++;
        if (cyc !== 1 || e !== 1'b1 || rd !== 32'h0000AAAD) begin
            tests_failed++;
            $display("FAIL sw_misaligned: cycles=%0d err=%b rdata=%h want 1/1/0000aaad", cyc, e, rd);
        end
        do_req(0, 0, 2'b11, 32'h10, 32'h0, rd, e, cyc, bc, ee);
        tests_run++;
        if (cyc !== 1 || e !== 1'b1) begin
            tests_failed++;
            $display("FAIL size_none: cycles=%0d err=%b want 1/1", cyc, e);
        end
        do_req(0, 0, 2'b00, 32'h20, 32'h0, rd, e, cyc, bc, ee);
        tests_run++;
        if (rd !== 32'h55667788 || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL word_untouched: got %h err=%b want 55667788/0", rd, e);
        end
    endtask

    task automatic test_range();
        logic [31:0] rd; logic e; int cyc, bc; bit ee;
        do_req(0, 0, 2'b00, 32'h00001000, 32'h0, rd, e, cyc, bc, ee);
        tests_run++;
        if (e !== 1'b1 || cyc !== 1 || rd !== 32'h55667788) begin
            tests_failed++;
            $display("FAIL range_over: err=%b cycles=%0d rdata=%h want 1/1/55667788", e, cyc, rd);
        end
        do_req(0, 1, 2'b00, 32'h00000FFC, 32'hCAFEF00D, rd, e, cyc, bc, ee);
        do_req(0, 0, 2'b00, 32'h00000FFC, 32'h0, rd, e, cyc, bc, ee);
        tests_run++;
        if (e !== 1'b0 || cyc !== 3 || rd !== 32'hCAFEF00D) begin
            tests_failed++;
            $display("FAIL range_last: err=%b cycles=%0d rdata=%h want 0/3/cafef00d", e, cyc, rd);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic e; int cyc, bc; bit ee;
        do_req(0, 1, 2'b00, 32'h20, 32'h00000000, rd, e, cyc, bc, ee);
        @(posedge clk); #1;
        we = 1'b1; access_size = 2'b00; addr = 32'h20; wdata = 32'h12345678;
        req_a = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (busy_a !== 1'b1 || done_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_in_wait: busy=%b done=%b want 1/0", busy_a, done_a);
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || err_a !== 1'b0 || rdata_a !== 32'h0) begin
            tests_failed++;
            $display("FAIL abort_outputs: busy=%b done=%b err=%b rdata=%h want 0/0/0/0",
                     busy_a, done_a, err_a, rdata_a);
        end
        req_a = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_req(0, 0, 2'b00, 32'h20, 32'h0, rd, e, cyc, bc, ee);
        tests_run++;
        if (rd !== 32'h00000000 || cyc !== 3) begin
            tests_failed++;
            $display("FAIL abort_no_write: got %h cycles=%0d want 00000000/3", rd, cyc);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic e; int cyc, bc; bit ee;
        @(posedge clk); #1;
        we = 1'b1; access_size = 2'b00; addr = 32'h40; wdata = 32'hA5A55A5A;
        req_b = 1'b1;
        #1;
        tests_run++;
        if (busy_b !== 1'b1 || done_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_sw_accept: busy=%b done=%b want 1/0", busy_b, done_b);
        end
        @(posedge clk); #1;
        we = 1'b0; wdata = 32'h0;
        #1;
        tests_run++;
        if (done_b !== 1'b1 || busy_b !== 1'b0 || err_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_sw_done: done=%b busy=%b err=%b want 1/0/0", done_b, busy_b, err_b);
        end
        @(posedge clk); #2;
        tests_run++;
        if (busy_b !== 1'b1 || done_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_lw_accept: busy=%b done=%b want 1/0", busy_b, done_b);
        end
        @(posedge clk); #1;
        tests_run++;
        if (done_b !== 1'b1 || busy_b !== 1'b0 || rdata_b !== 32'hA5A55A5A) begin
            tests_failed++;
            $display("FAIL b2b_lw_done: done=%b busy=%b rdata=%h want 1/0/a5a55a5a", done_b, busy_b, rdata_b);
        end
        req_b = 1'b0;
        do_req(1, 1, 2'b10, 32'h41, 32'h0000003C, rd, e, cyc, bc, ee);
        tests_run++;
        if (cyc !== 1 || bc !== 1 || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_sb_timing: cycles=%0d busy=%0d err=%b want 1/1/0", cyc, bc, e);
        end
        do_req(1, 0, 2'b00, 32'h40, 32'h0, rd, e, cyc, bc, ee);
        tests_run++;
        if (rd !== 32'hA5A53C5A || cyc !== 1) begin
            tests_failed++;
            $display("FAIL b2b_lw_after_sb: got %h cycles=%0d want a5a53c5a/1", rd, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_subword();
        test_illegal();
        test_range();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the internal data array.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted before completion; legal range 0-15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  1  memory access request from memory stage (require_mem_access).
REQ-006 we  input  1  store when 1, load when 0 (write_to_data_mem); sampled only with req.
REQ-007 access_size  input  2  00 word, 01 half, 10 byte, 11 none.
REQ-008 addr  input  32  byte address.
REQ-009 wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 rdata  output  32  load data, right-aligned, zero-extended; sign extension is done downstream.
REQ-011 busy  output  1  stall to pipeline; pipeline holds all request inputs while 1.
REQ-012 done  output  1  one-cycle completion pulse; rdata and err valid in this cycle.
REQ-013 err  output  1  request rejected: misaligned, out of range, or access_size 11.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, DONE.
REQ-015 IDLE: req=0 -> stay IDLE; req=1 -> latch we, access_size, addr, wdata; go WAIT if WAIT_CYCLES>0 and request legal, else DONE.
REQ-016 WAIT: wait counter loaded with WAIT_CYCLES-1 on entry, decrements each cycle; at 0 -> DONE.
REQ-017 DONE: lasts exactly one cycle, done=1, then IDLE unconditionally; req during DONE is ignored.
REQ-018 busy SHALL be combinational: 1 when (state==IDLE and req=1) or state==WAIT; 0 in DONE and in idle IDLE.
REQ-019 Latency: request accepted in cycle N completes (done=1) in cycle N+1+WAIT_CYCLES; illegal request completes in N+1.
REQ-020 Illegal: half with addr[0]=1; word with addr[1:0]!=00; access_size 11; addr[31:2] >= DEPTH_WORDS.
REQ-021 Illegal request: err=1 with done, no array write, rdata unchanged.
REQ-022 Legal store: array written once, on the clock edge entering DONE, using byte enables only; other lanes unchanged.
REQ-023 Byte enables: byte -> lane addr[1:0]; half -> lanes {addr[1],0} and {addr[1],1}; word -> all four.
REQ-024 Store lane data: byte wdata[7:0] replicated x4; half wdata[15:0] replicated x2; word as-is.
REQ-025 Legal load: rdata registered on edge entering DONE: selected lane(s) shifted to bit 0, upper bits 0.
REQ-026 Store completion: rdata unchanged, err=0.
REQ-027 rdata SHALL hold its value until the next legal load completes.
REQ-028 err SHALL be 0 outside DONE.
REQ-029 Word index is addr[31:2]; addr bits above log2(DEPTH_WORDS)+2 participate only in the range check.
REQ-030 Read-after-write to same word in consecutive requests SHALL return the newly written data.

Reset
REQ-031 rst_n=0 SHALL force state IDLE, wait counter 0, done 0, err 0, rdata 0 immediately, without a clock.
REQ-032 busy SHALL be 0 during reset regardless of req.
REQ-033 Reset during WAIT SHALL abort the request: no array write occurs.
REQ-034 Array contents are not initialised by reset.
REQ-035 First request is accepted on the first rising edge with rst_n=1 and req=1.

Verification
REQ-036 WAIT_CYCLES=2: SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> busy 3 cycles each, done in cycle N+3, rdata 0xDEADBEEF, err 0.
REQ-037 After REQ-036, SB addr 0x13 wdata 0x000000AA; LW 0x10 -> rdata 0xAAADBEEF; LB 0x12 -> rdata 0x000000AD; LH 0x12 -> 0x0000AAAD.
REQ-038 LH addr 0x11, then SW addr 0x22 -> each: done+err=1 one cycle after accept, word unchanged, rdata holds prior value.
REQ-039 DEPTH_WORDS=1024: LW addr 0x00001000 -> err=1; LW 0x00000FFC -> err=0.
REQ-040 SW addr 0x20 0x12345678 with rst_n pulsed low during WAIT -> outputs 0 immediately, state IDLE; later LW 0x20 does not return 0x12345678 (preload 0 first).
REQ-041 WAIT_CYCLES=0: back-to-back SW/LW same address -> done every second cycle, busy 1 in accept cycle only, LW returns stored value.
